// File: rtl/tweakey_reg_bank_if.sv
// Command/data bundle between the input-bus side, the round function and the tweakey register bank.
interface tweakey_reg_bank_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
);
    logic                   enc;
    logic [WIDTH-1:0]       si;
    logic                   ld;
    logic                   start;
    logic                   restore;
    logic [WIDTH*LANES-1:0] skinnys;
    logic [WIDTH*LANES-1:0] so;
    logic [5:0]             round;
    logic                   busy;
    logic                   loaded;
    logic                   done;

    modport master (
        output enc, si, ld, start, restore, skinnys,
        input  so, round, busy, loaded, done
    );

    modport slave (
        input  enc, si, ld, start, restore, skinnys,
        output so, round, busy, loaded, done
    );
endinterface

// File: rtl/tweakey_reg_bank.sv
// LANES x WIDTH tweakey state with serial load, ROUNDS-long schedule run and shadow restore.
module tweakey_reg_bank #(
    parameter int                       WIDTH      = 32,
    parameter int                       LANES      = 4,
    parameter int                       ROUNDS     = 40,
    parameter logic [WIDTH*LANES-1:0]   INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    tweakey_reg_bank_if.slave bus
);
    localparam int SW     = WIDTH * LANES;
    localparam int LCNT_W = $clog2(LANES + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_nxt;
    logic [SW-1:0]       so_q, shadow_q;
    logic [5:0]          round_q;
    logic [LCNT_W-1:0]   lcnt_q;
    logic [LCNT_W-1:0]   lcnt_inc;
    logic                loaded_q, done_q, busy;
    logic                last_round;
    logic                start_ok;

    assign lcnt_inc   = lcnt_q + LCNT_W'(1);
    assign last_round = (round_q == 6'(ROUNDS - 1));
    // restore and ld outrank start, so start only launches when both are idle.
    assign start_ok   = !bus.restore && !bus.ld && bus.start && loaded_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          state <= IDLE;
        else if (bus.enc) state <= state_nxt;
    end

    // NOTE: default assignment first keeps this comb process free of inferred latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)   state_nxt = RUN;
            RUN:     if (last_round) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            so_q     <= INIT_VALUE;
            shadow_q <= INIT_VALUE;
            round_q  <= '0;
            lcnt_q   <= '0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // done is a pulse: cleared on every edge, enc or not, unless set below.
            done_q <= 1'b0;
            if (bus.enc) begin
                if (state == RUN) begin
                    so_q <= bus.skinnys;
                    if (last_round) begin
                        round_q <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        round_q <= round_q + 6'd1;
                    end
                end else if (bus.restore) begin
                    so_q <= shadow_q;
                end else if (bus.ld) begin
                    so_q <= {so_q[SW-WIDTH-1:0], bus.si};
                    if (loaded_q) begin
                        loaded_q <= 1'b0;
                        lcnt_q   <= LCNT_W'(1);
                    end else if (lcnt_inc == LCNT_W'(LANES)) begin
                        loaded_q <= 1'b1;
                        lcnt_q   <= '0;
                    end else begin
                        lcnt_q   <= lcnt_inc;
                    end
                end else if (start_ok) begin
                    shadow_q <= so_q;
                    round_q  <= '0;
                end
            end
        end
    end

    assign bus.so     = so_q;
    assign bus.round  = round_q;
    assign bus.busy   = busy;
    assign bus.loaded = loaded_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_tweakey_reg_bank.sv
// Self-checking bench: load vector table, hand-written run/restore/stall/reset sequences, random commands vs model.
module tb_tweakey_reg_bank;
    localparam int WIDTH  = 32;
    localparam int LANES  = 4;
    localparam int ROUNDS = 40;
    localparam int SW     = WIDTH * LANES;
    localparam logic [SW-1:0] BASE = 128'h000102030405060708090A0B0C0D0E0F;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tweakey_reg_bank_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    tweakey_reg_bank #(.WIDTH(WIDTH), .LANES(LANES), .ROUNDS(ROUNDS), .INIT_VALUE('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Round function stand-in: next tweakey is the current one plus one.
    assign bus.skinnys = bus.so + 1'b1;

    // Reference model: the tweakey as one wide number, words collected so far, and rounds left to run.
    logic [SW-1:0] m_so, m_shadow;
    int            m_round, m_words, m_left;
    bit            m_loaded, m_done;

    typedef struct {
        logic          enc, ld, start, restore;
        logic [31:0]   si;
        logic [SW-1:0] so;
        logic          loaded, busy;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_so = '0; m_shadow = '0; m_round = 0; m_words = 0; m_left = 0;
        m_loaded = 0; m_done = 0;
    endtask

    task automatic model_step();
        m_done = 0;
        if (!bus.enc) return;
        if (m_left > 0) begin
            m_so = m_so + 1;
            m_left--;
            m_round = ROUNDS - m_left;
            if (m_left == 0) begin
                m_round = 0;
                m_done  = 1;
            end
        end else if (bus.restore) begin
            m_so = m_shadow;
        end else if (bus.ld) begin
            m_so = (m_so << WIDTH) | SW'(bus.si);
            if (m_loaded) begin
                m_loaded = 0;
                m_words  = 1;
            end else begin
                m_words++;
                if (m_words == LANES) begin
                    m_loaded = 1;
                    m_words  = 0;
                end
            end
        end else if (bus.start && m_loaded) begin
            m_shadow = m_so;
            m_round  = 0;
            m_left   = ROUNDS;
        end
    endtask

    task automatic compare_model();
        check("mdl_so",     bus.so,           m_so);
        check("mdl_round",  SW'(bus.round),   SW'(m_round));
        check("mdl_busy",   SW'(bus.busy),    SW'(m_left > 0));
        check("mdl_loaded", SW'(bus.loaded),  SW'(m_loaded));
        check("mdl_done",   SW'(bus.done),    SW'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic idle_inputs();
        bus.enc = 1'b1; bus.ld = 1'b0; bus.start = 1'b0; bus.restore = 1'b0; bus.si = '0;
    endtask

    // Pulses start, then runs until busy falls, optionally stalling enc for 5 cycles at one round.
    task automatic run(input int stall_at, output int clocks, output int dones);
        bit stalled = 0;
        clocks = 0; dones = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("run_busy_after_start", SW'(bus.busy), SW'(1));
        while (bus.busy && clocks < 200) begin
            if (!stalled && int'(bus.round) == stall_at) begin
                bus.enc = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    bus.ld = 1'($urandom); bus.si = $urandom;
                    tick();
                    clocks++;
                    check("stall_round", SW'(bus.round), SW'(stall_at));
                end
                bus.enc = 1'b1;
                stalled = 1;
            end else begin
                bus.ld = 1'($urandom); bus.si = $urandom;
                tick();
                clocks++;
                if (bus.done) dones++;
            end
        end
        bus.ld = 1'b0;
        tick();
        check("done_cleared", SW'(bus.done), SW'(0));
    endtask

    initial begin
        int clocks, dones, n;

        vecs[0] = '{1, 1, 0, 0, 32'h00010203, 128'h00010203, 0, 0};
        vecs[1] = '{1, 1, 0, 0, 32'h04050607, 128'h0001020304050607, 0, 0};
        vecs[2] = '{1, 1, 0, 0, 32'h08090A0B, 128'h000102030405060708090A0B, 0, 0};
        vecs[3] = '{1, 0, 1, 0, 32'h0,        128'h000102030405060708090A0B, 0, 0};
        vecs[4] = '{1, 1, 0, 0, 32'h0C0D0E0F, BASE, 1, 0};
        vecs[5] = '{0, 1, 0, 0, 32'hFFFFFFFF, BASE, 1, 0};

        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Asynchronous reset after partial load: takes effect with no clock edge.
        bus.ld = 1'b1; bus.si = 32'hDEADBEEF; tick();
        bus.si = 32'h12345678; tick();
        bus.ld = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_so",     bus.so,             '0);
        check("rst_busy",   SW'(bus.busy),      SW'(0));
        check("rst_loaded", SW'(bus.loaded),    SW'(0));
        check("rst_round",  SW'(bus.round),     SW'(0));
        check("rst_done",   SW'(bus.done),      SW'(0));
        @(negedge clk) rst = 1'b0;
        bus.restore = 1'b1; tick(); bus.restore = 1'b0;
        check("rst_shadow", bus.so, '0);

        foreach (vecs[i]) begin
            bus.enc = vecs[i].enc; bus.ld = vecs[i].ld; bus.start = vecs[i].start;
            bus.restore = vecs[i].restore; bus.si = vecs[i].si;
            tick();
            check($sformatf("vec%0d_so", i),     bus.so,             vecs[i].so);
            check($sformatf("vec%0d_loaded", i), SW'(bus.loaded),    SW'(vecs[i].loaded));
            check($sformatf("vec%0d_busy", i),   SW'(bus.busy),      SW'(vecs[i].busy));
        end
        idle_inputs();

        run(-1, clocks, dones);
        check("run1_clocks", SW'(clocks), SW'(ROUNDS));
        check("run1_dones",  SW'(dones),  SW'(1));
        check("run1_so",     bus.so,      BASE + SW'(ROUNDS));
        check("run1_loaded", SW'(bus.loaded), SW'(1));

        bus.restore = 1'b1; bus.ld = 1'b1; bus.si = 32'hA5A5A5A5; tick();
        idle_inputs();
        check("restore_wins", bus.so, BASE);
        run(-1, clocks, dones);
        check("run2_so",     bus.so,      BASE + SW'(ROUNDS));
        check("run2_dones",  SW'(dones),  SW'(1));

        bus.restore = 1'b1; tick(); bus.restore = 1'b0;
        run(12, clocks, dones);
        check("stall_clocks", SW'(clocks), SW'(ROUNDS + 5));
        check("stall_dones",  SW'(dones),  SW'(1));
        check("stall_so",     bus.so,      BASE + SW'(ROUNDS));

        // Reset in the middle of a run: immediate abort, no done, loaded lost.
        bus.restore = 1'b1; tick(); bus.restore = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n = 0;
        while (bus.round != 6'd17 && n < 100) begin tick(); n++; end
        check("reach_round17", SW'(bus.round), SW'(17));
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("midrun_so",   bus.so,          '0);
        check("midrun_busy", SW'(bus.busy),   SW'(0));
        @(posedge clk); #1;
        check("midrun_done", SW'(bus.done),   SW'(0));
        rst = 1'b0;
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        check("start_unloaded", SW'(bus.busy), SW'(0));

        for (int i = 0; i < 1500; i++) begin
            bus.enc     = ($urandom % 8) != 0;
            bus.ld      = ($urandom % 3) == 0;
            bus.start   = ($urandom % 5) == 0;
            bus.restore = ($urandom % 9) == 0;
            bus.si      = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tweakey_reg_bank.md
Name: tweakey_reg_bank

Overview:
Parametrised tweakey state register for the SKINNY-based Romulus datapath. It generalises the single-word clock-gated key register into a LANES×WIDTH state with several features:
- serial word loading
- a round counter that runs the tweakey schedule for ROUNDS updates
- a shadow copy so the original tweakey can be restored for the next block without reloading

The block sits between the input bus (key/tweak/nonce words) and the SKINNY round function, which supplies the next-round tweakey on skinnys.

Parameters:
WIDTH, 32, bus word width in bits
LANES, 4, number of words in the state; state width is WIDTH*LANES
ROUNDS, 40, tweakey updates per run (valid range 1..63)
INIT_VALUE, 0, reset value of the state and shadow registers (WIDTH*LANES bits)

Ports:
clk  input  1  clock; all flops are rising-edge
rst  input  1  reset, asynchronous, active-high
enc  input  1  synchronous clock enable; when low, all state except done holds (replaces the latch-based gated clock)
si  input  WIDTH  serial load word
ld  input  1  load strobe for si
start  input  1  begin a ROUNDS-long schedule run
restore  input  1  copy shadow back into the state
skinnys  input  WIDTH*LANES  next-round tweakey from the round function (combinational from so)
so  output  WIDTH*LANES  current tweakey state
round  output  6  current round index
busy  output  1  high while in RUN
loaded  output  1  a full LANES-word load has completed since the last ld sequence began
done  output  1  one-cycle pulse at the end of a run

Behaviour:
- Reset, asynchronous on rst=1, to:
  - so=INIT_VALUE, shadow=INIT_VALUE
  - round=0, load counter lcnt=0
  - loaded=0, busy=0, done=0
  - FSM=IDLE
  - Reset mid-run aborts the run immediately, with no done pulse.
- FSM states: IDLE and RUN. busy = (FSM==RUN).
- IDLE, enc=1, command priority restore > ld > start; only one command acts per cycle.
  - restore: so <= shadow; lcnt and loaded are unchanged.
  - ld:
    - so <= {so[(LANES-1)*WIDTH-1:0], si}, so the first word loaded ends in the most-significant lane.
    - If loaded=1, first loaded <= 0 and lcnt <= 1 (a new load sequence begins).
    - Otherwise lcnt <= lcnt+1. When lcnt+1==LANES: loaded <= 1 and lcnt <= 0.
  - start with loaded=1: shadow <= so, round <= 0, FSM <= RUN.
  - start with loaded=0: ignored, no state change.
- RUN, enc=1:
  - so <= skinnys.
  - If round==ROUNDS-1: round <= 0, FSM <= IDLE, done <= 1. Otherwise round <= round+1.
  - ld, start and restore are ignored in RUN.
- Run latency: exactly ROUNDS enc-qualified cycles from the start edge to the busy falling edge. done is high for the cycle after the final update.
- enc=0: so, shadow, round, lcnt, loaded and FSM hold. done still clears on the next edge, so it is a pulse of exactly one clock.
- done is registered and cleared on every clock edge where it is not being set.
- loaded stays 1 through and after a run, so back-to-back runs with restore need no reload.
- so is registered; there is no combinational path from any input to so.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle → so=0, shadow=0, busy=0, loaded=0, round=0, done=0 without waiting for a clock edge.
2. Load: enc=1; ld with si=0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F on four cycles → so=0x000102030405060708090A0B0C0D0E0F; loaded rises after the fourth ld; a start issued after only three words is ignored (busy stays 0).
3. Run: start with the bench model skinnys=so+1 → busy high for 40 cycles, round steps 0..39, so=0x...0E0F+40 (low word 0x0C0D0E37); done is a single-cycle pulse; ld pulses during the run leave so unaffected.
4. Restore and priority: after the run, assert restore and ld together → so=0x000102030405060708090A0B0C0D0E0F (restore wins); then start again → a second 40-round run gives the same final value.
5. Enable stall: drop enc for 5 cycles at round 12 → round and so frozen at 12; run completes 45 clocks after start; done still lasts one clock.
6. Reset mid-run: assert rst at round 17 → so=INIT_VALUE, busy=0, no done pulse; a subsequent start with no reload is ignored because loaded=0.
